// File: rtl/sram_req_arbiter.sv
// Multi-master SRAM-like request arbiter with lockable grant and an in-order ID FIFO for response routing.
// Optional build macro SRAM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module sram_req_arbiter #(
  parameter int NUM_MST = 2,
  parameter int DEPTH   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_MST-1:0]          m_req,
  input  logic [NUM_MST-1:0]          m_wr,
  input  logic [2*NUM_MST-1:0]        m_size,
  input  logic [(DW/8)*NUM_MST-1:0]   m_wstrb,
  input  logic [AW*NUM_MST-1:0]       m_addr,
  input  logic [DW*NUM_MST-1:0]       m_wdata,
  output logic [NUM_MST-1:0]          m_addr_ok,
  output logic [NUM_MST-1:0]          m_data_ok,
  output logic [DW-1:0]               m_rdata,
  output logic                        s_req,
  output logic                        s_wr,
  output logic [1:0]                  s_size,
  output logic [DW/8-1:0]             s_wstrb,
  output logic [AW-1:0]               s_addr,
  output logic [DW-1:0]               s_wdata,
  input  logic                        s_addr_ok,
  input  logic                        s_data_ok,
  input  logic [DW-1:0]               s_rdata,
  output logic                        err_orphan
);

  localparam int IW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = DW / 8;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_lock_idx;
  logic [IW-1:0]   w_free_gnt;
  logic            w_free_vld;
  logic [IW-1:0]   w_gnt;
  logic            w_gnt_vld;
  logic            w_hs;
  logic            w_full;
  logic            w_pop;
  logic            w_orphan;
  logic [IW-1:0]   w_head;

  logic [IW-1:0]   r_fifo [DEPTH];
  logic [FW-1:0]   r_wr_ptr;
  logic [FW-1:0]   r_rd_ptr;
  logic [FW:0]     r_cnt;
  logic            r_err;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest requesting index is the last one written.
  always_comb begin
    w_free_gnt = '0;
    w_free_vld = 1'b0;
    for (int k = NUM_MST - 1; k >= 0; k--) begin
      if (m_req[k]) begin
        w_free_vld = 1'b1;
        w_free_gnt = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_rr_idx;

  // Search starts at r_ptr and wraps; first requester found wins.
  always_comb begin
    w_free_gnt = '0;
    w_free_vld = 1'b0;
    w_rr_idx   = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      w_rr_idx = IW'((int'(r_ptr) + k) % NUM_MST);
      if (!w_free_vld && m_req[w_rr_idx]) begin
        w_free_vld = 1'b1;
        w_free_gnt = w_rr_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= IW'((int'(w_gnt) + 1) % NUM_MST);
    end
  end
`endif

  assign w_gnt     = (r_state == ST_LOCKED) ? r_lock_idx : w_free_gnt;
  assign w_gnt_vld = (r_state == ST_LOCKED) ? m_req[r_lock_idx] : w_free_vld;
  assign w_full    = (r_cnt == (FW+1)'(DEPTH));

  assign s_req   = !reset && w_gnt_vld && !w_full;
  assign w_hs    = s_req && s_addr_ok;
  assign s_wr    = m_wr[w_gnt];
  assign s_size  = m_size[int'(w_gnt)*2 +: 2];
  assign s_wstrb = m_wstrb[int'(w_gnt)*SW +: SW];
  assign s_addr  = m_addr[int'(w_gnt)*AW +: AW];
  assign s_wdata = m_wdata[int'(w_gnt)*DW +: DW];

  always_comb begin
    m_addr_ok = '0;
    if (w_hs) m_addr_ok[w_gnt] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (s_req && !s_addr_ok) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_hs) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_lock_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && s_req && !s_addr_ok) r_lock_idx <= w_gnt;
    end
  end

  // Response side: the slave is in-order, so the FIFO head names the owner of each s_data_ok.
  assign w_head   = r_fifo[r_rd_ptr];
  assign w_pop    = !reset && s_data_ok && (r_cnt != '0);
  assign w_orphan = s_data_ok && (r_cnt == '0);
  assign m_rdata  = s_rdata;

  always_comb begin
    m_data_ok = '0;
    if (w_pop) m_data_ok[w_head] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_hs) r_fifo[r_wr_ptr] <= w_gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_hs)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_orphan) r_err <= 1'b1;
    end
  end

  assign err_orphan = r_err;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed table-driven bench for sram_req_arbiter (NUM_MST=2, DEPTH=4); each record is one clock cycle.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m_req;
  logic [1:0]  m_wr;
  logic [3:0]  m_size;
  logic [7:0]  m_wstrb;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [1:0]  m_addr_ok;
  logic [1:0]  m_data_ok;
  logic [31:0] m_rdata;
  logic        s_req;
  logic        s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_addr_ok;
  logic        s_data_ok;
  logic [31:0] s_rdata;
  logic        err_orphan;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.NUM_MST(2), .DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .err_orphan(err_orphan)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        esreq;
    int          eg;
    logic [1:0]  emaok;
    logic [1:0]  emdok;
    logic        eerr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [1:0] req, input logic aok, input logic dok,
                     input logic [31:0] rdata, input logic esreq, input int eg,
                     input logic [1:0] emaok, input logic [1:0] emdok, input logic eerr);
    vec_t v;
    v.rst = rst; v.req = req; v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.esreq = esreq; v.eg = eg; v.emaok = emaok; v.emdok = emdok; v.eerr = eerr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int g);
    return (g == 1) ? 32'h0000_0200 : 32'h0000_0100;
  endfunction

  function automatic logic [31:0] exp_wdata(input int g);
    return (g == 1) ? 32'hD1D1_D1D1 : 32'hD0D0_D0D0;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    reset     = v.rst;
    m_req     = v.req;
    s_addr_ok = v.aok;
    s_data_ok = v.dok;
    s_rdata   = v.rdata;
    #3;
    chk({tag, " s_req"}, 64'(s_req), 64'(v.esreq));
    chk({tag, " m_addr_ok"}, 64'(m_addr_ok), 64'(v.emaok));
    chk({tag, " m_data_ok"}, 64'(m_data_ok), 64'(v.emdok));
    chk({tag, " err_orphan"}, 64'(err_orphan), 64'(v.eerr));
    if (v.esreq) begin
      chk({tag, " s_addr"}, 64'(s_addr), 64'(exp_addr(v.eg)));
      chk({tag, " s_wdata"}, 64'(s_wdata), 64'(exp_wdata(v.eg)));
      chk({tag, " s_wr"}, 64'(s_wr), (v.eg == 1) ? 64'd1 : 64'd0);
      chk({tag, " s_size"}, 64'(s_size), (v.eg == 1) ? 64'd2 : 64'd1);
      chk({tag, " s_wstrb"}, 64'(s_wstrb), (v.eg == 1) ? 64'hC : 64'h3);
    end
    if (v.dok) chk({tag, " m_rdata"}, 64'(m_rdata), 64'(v.rdata));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t h;
    m_wr    = 2'b10;
    m_size  = 4'b10_01;
    m_wstrb = 8'hC3;
    m_addr  = {32'h0000_0200, 32'h0000_0100};
    m_wdata = {32'hD1D1_D1D1, 32'hD0D0_D0D0};
    m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // rst req aok dok rdata | s_req g m_addr_ok m_data_ok err
    add(1, 2'b11, 1, 1, 32'h0,  0, 0, 2'b00, 2'b00, 0);
`ifdef SRAM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) add(0, 2'b11, 1, 0, 32'h0, 1, 0, 2'b01, 2'b00, 0);
    add(0, 2'b11, 1, 0, 32'h0,  0, 0, 2'b00, 2'b00, 0);
    add(0, 2'b11, 1, 1, 32'h55, 0, 0, 2'b00, 2'b01, 0);
    add(0, 2'b11, 1, 0, 32'h0,  1, 0, 2'b01, 2'b00, 0);
`else
    add(0, 2'b11, 1, 0, 32'h0,  1, 0, 2'b01, 2'b00, 0);
    add(0, 2'b11, 1, 0, 32'h0,  1, 1, 2'b10, 2'b00, 0);
    add(0, 2'b11, 1, 0, 32'h0,  1, 0, 2'b01, 2'b00, 0);
    add(0, 2'b11, 1, 0, 32'h0,  1, 1, 2'b10, 2'b00, 0);
    add(0, 2'b11, 1, 0, 32'h0,  0, 0, 2'b00, 2'b00, 0);
    add(0, 2'b11, 1, 1, 32'h11, 0, 0, 2'b00, 2'b01, 0);
    add(0, 2'b11, 1, 0, 32'h0,  1, 0, 2'b01, 2'b00, 0);
    add(0, 2'b00, 0, 1, 32'h22, 0, 0, 2'b00, 2'b10, 0);
    add(0, 2'b00, 0, 1, 32'h23, 0, 0, 2'b00, 2'b01, 0);
    add(0, 2'b00, 0, 1, 32'h24, 0, 0, 2'b00, 2'b10, 0);
    add(0, 2'b00, 0, 1, 32'h25, 0, 0, 2'b00, 2'b01, 0);
    add(0, 2'b00, 0, 1, 32'h26, 0, 0, 2'b00, 2'b00, 0);
    add(0, 2'b00, 0, 0, 32'h0,  0, 0, 2'b00, 2'b00, 1);
    add(0, 2'b10, 1, 0, 32'h0,  1, 1, 2'b10, 2'b00, 1);
    add(0, 2'b10, 0, 0, 32'h0,  1, 1, 2'b00, 2'b00, 1);
    add(0, 2'b10, 0, 0, 32'h0,  1, 1, 2'b00, 2'b00, 1);
    add(0, 2'b11, 0, 0, 32'h0,  1, 1, 2'b00, 2'b00, 1);
    add(0, 2'b11, 1, 0, 32'h0,  1, 1, 2'b10, 2'b00, 1);
    add(0, 2'b11, 1, 0, 32'h0,  1, 0, 2'b01, 2'b00, 1);
    add(0, 2'b00, 0, 1, 32'h33, 0, 0, 2'b00, 2'b10, 1);
    add(0, 2'b00, 0, 1, 32'h34, 0, 0, 2'b00, 2'b10, 1);
    add(0, 2'b00, 0, 1, 32'h35, 0, 0, 2'b00, 2'b01, 1);
    add(0, 2'b10, 1, 0, 32'h0,  1, 1, 2'b10, 2'b00, 1);
    add(0, 2'b01, 1, 0, 32'h0,  1, 0, 2'b01, 2'b00, 1);
    add(0, 2'b10, 1, 0, 32'h0,  1, 1, 2'b10, 2'b00, 1);
    add(0, 2'b00, 0, 1, 32'hA,  0, 0, 2'b00, 2'b10, 1);
    add(0, 2'b00, 0, 1, 32'hB,  0, 0, 2'b00, 2'b01, 1);
    add(0, 2'b00, 0, 1, 32'hC,  0, 0, 2'b00, 2'b10, 1);
    add(0, 2'b11, 1, 0, 32'h0,  1, 0, 2'b01, 2'b00, 1);
    add(0, 2'b11, 1, 0, 32'h0,  1, 1, 2'b10, 2'b00, 1);
    add(0, 2'b01, 1, 0, 32'h0,  1, 0, 2'b01, 2'b00, 1);
    add(1, 2'b11, 1, 1, 32'h44, 0, 0, 2'b00, 2'b00, 1);
    add(0, 2'b00, 0, 1, 32'h45, 0, 0, 2'b00, 2'b00, 0);
    add(0, 2'b11, 1, 0, 32'h0,  1, 0, 2'b01, 2'b00, 1);
`endif

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // Reset while LOCKED on master 1 must release the lock.
    reset = 1'b1; @(posedge clk); #1;
    h.rst = 0; h.req = 2'b10; h.aok = 0; h.dok = 0; h.rdata = '0;
    h.esreq = 1; h.eg = 1; h.emaok = 2'b00; h.emdok = 2'b00; h.eerr = 0;
    apply(h, "lk0");
    apply(h, "lk1");
    h.rst = 1; h.req = 2'b11; h.esreq = 0; h.eg = 0;
    apply(h, "lk_rst");
    h.rst = 0; h.aok = 1; h.esreq = 1; h.eg = 0; h.emaok = 2'b01;
    apply(h, "lk_rel");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
